alu_exec: RTL and testbench

Integer execution stage that sits directly downstream of the reservation station. It accepts at most one issued operation per cycle on the `alu_*` bus and evaluates it in the same cycle. Results go into a small result FIFO, and the FIFO head is presented on the ALU CDB channel until the CDB arbiter grants it. A near-full flag goes back to the pipeline stall logic, and a rollback empties the unit.

---
 rtl/alu_exec_if.sv | 30 +++
 rtl/alu_exec.sv | 140 ++++++++++++++
 tb/tb_alu_exec.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// Issue bus, CDB channel and stall/rollback controls between the RS, the ALU stage and the
// CDB arbiter.
interface alu_exec_if;
   logic        rdy;
   logic        ex_rb;
   logic        alu_ena;
   logic [4:0]  alu_opt;
   logic [31:0] alu_val1;
   logic [31:0] alu_val2;
   logic [31:0] alu_imm;
   logic [3:0]  alu_rob_idx;
   logic        ex_full;
   logic        cdb_alu_valid;
   logic [3:0]  cdb_alu_src;
   logic [31:0] cdb_alu_val;
   logic        cdb_alu_br;
   logic        cdb_alu_gnt;

   modport master (
      output rdy, ex_rb, alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx,
             cdb_alu_gnt,
      input  ex_full, cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_alu_br
   );

   modport slave (
      input  rdy, ex_rb, alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx,
             cdb_alu_gnt,
      output ex_full, cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_alu_br
   );
endinterface

// File: rtl/alu_exec.sv
// Single-cycle integer execution stage: evaluates the issued op and queues {tag, result, br}
// in a circular FIFO whose head is offered on the ALU CDB channel.
module alu_exec #(
   parameter int unsigned FIFO_BIT = 2
) (
   input logic       clk,
   input logic       rst,
   alu_exec_if.slave bus_io
);
   localparam int unsigned Depth = 1 << FIFO_BIT;
   localparam int unsigned EntW  = 4 + 32 + 1;

   localparam logic [4:0] OPT_NONE  = 5'd0;
   localparam logic [4:0] OPT_ADD   = 5'd1;
   localparam logic [4:0] OPT_SUB   = 5'd2;
   localparam logic [4:0] OPT_AND   = 5'd3;
   localparam logic [4:0] OPT_OR    = 5'd4;
   localparam logic [4:0] OPT_XOR   = 5'd5;
   localparam logic [4:0] OPT_SLL   = 5'd6;
   localparam logic [4:0] OPT_SRL   = 5'd7;
   localparam logic [4:0] OPT_SRA   = 5'd8;
   localparam logic [4:0] OPT_SLT   = 5'd9;
   localparam logic [4:0] OPT_SLTU  = 5'd10;
   localparam logic [4:0] OPT_ADDI  = 5'd11;
   localparam logic [4:0] OPT_ANDI  = 5'd12;
   localparam logic [4:0] OPT_ORI   = 5'd13;
   localparam logic [4:0] OPT_XORI  = 5'd14;
   localparam logic [4:0] OPT_SLLI  = 5'd15;
   localparam logic [4:0] OPT_SRLI  = 5'd16;
   localparam logic [4:0] OPT_SRAI  = 5'd17;
   localparam logic [4:0] OPT_SLTI  = 5'd18;
   localparam logic [4:0] OPT_SLTIU = 5'd19;
   localparam logic [4:0] OPT_LUI   = 5'd20;
   localparam logic [4:0] OPT_AUIPC = 5'd21;
   localparam logic [4:0] OPT_JAL   = 5'd22;
   localparam logic [4:0] OPT_JALR  = 5'd23;
   localparam logic [4:0] OPT_BEQ   = 5'd24;
   localparam logic [4:0] OPT_BNE   = 5'd25;
   localparam logic [4:0] OPT_BLT   = 5'd26;
   localparam logic [4:0] OPT_BGE   = 5'd27;
   localparam logic [4:0] OPT_BLTU  = 5'd28;
   localparam logic [4:0] OPT_BGEU  = 5'd29;

   typedef logic [FIFO_BIT-1:0] ptr_t;
   typedef logic [FIFO_BIT:0]   cnt_t;

   logic [EntW-1:0] mem_q [Depth];
   ptr_t            head_q, head_d, tail_q, tail_d;
   cnt_t            cnt_q, cnt_d;

   logic [31:0] opb, res;
   logic [4:0]  shamt;
   logic        br;
   logic        full, push, pop;
   logic [EntW-1:0] head_ent;

   always_comb begin
      res   = '0;
      br    = 1'b0;
      opb   = bus_io.alu_val2;
      if (bus_io.alu_opt >= OPT_ADDI && bus_io.alu_opt <= OPT_SLTIU) begin
         opb = bus_io.alu_imm;
      end
      shamt = opb[4:0];
      case (bus_io.alu_opt)
         OPT_ADD, OPT_ADDI:   res = bus_io.alu_val1 + opb;
         OPT_SUB:             res = bus_io.alu_val1 - opb;
         OPT_AND, OPT_ANDI:   res = bus_io.alu_val1 & opb;
         OPT_OR, OPT_ORI:     res = bus_io.alu_val1 | opb;
         OPT_XOR, OPT_XORI:   res = bus_io.alu_val1 ^ opb;
         OPT_SLL, OPT_SLLI:   res = bus_io.alu_val1 << shamt;
         OPT_SRL, OPT_SRLI:   res = bus_io.alu_val1 >> shamt;
         OPT_SRA, OPT_SRAI:   res = $unsigned($signed(bus_io.alu_val1) >>> shamt);
         OPT_SLT, OPT_SLTI:   res = {31'b0, $signed(bus_io.alu_val1) < $signed(opb)};
         OPT_SLTU, OPT_SLTIU: res = {31'b0, bus_io.alu_val1 < opb};
         OPT_LUI:             res = bus_io.alu_imm;
         OPT_AUIPC:           res = bus_io.alu_val1 + bus_io.alu_imm;
         OPT_JAL, OPT_JALR: begin
            res = bus_io.alu_val1 + 32'd4;
            br  = 1'b1;
         end
         OPT_BEQ:  br = bus_io.alu_val1 == bus_io.alu_val2;
         OPT_BNE:  br = bus_io.alu_val1 != bus_io.alu_val2;
         OPT_BLT:  br = $signed(bus_io.alu_val1) < $signed(bus_io.alu_val2);
         OPT_BGE:  br = $signed(bus_io.alu_val1) >= $signed(bus_io.alu_val2);
         OPT_BLTU: br = bus_io.alu_val1 < bus_io.alu_val2;
         OPT_BGEU: br = bus_io.alu_val1 >= bus_io.alu_val2;
         OPT_NONE: ;
         default:  ;
      endcase
   end

   assign full = cnt_q == cnt_t'(Depth);
   assign pop  = bus_io.rdy && (cnt_q != '0) && bus_io.cdb_alu_gnt && !bus_io.ex_rb;
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign push = bus_io.rdy && bus_io.alu_ena && !bus_io.ex_rb && (!full || pop);

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (bus_io.ex_rb) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end else begin
         if (pop) head_d = head_q + ptr_t'(1);
         if (push) tail_d = tail_q + ptr_t'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + cnt_t'(1);
            2'b01:   cnt_d = cnt_q - cnt_t'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else if (bus_io.rdy || bus_io.ex_rb) begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[tail_q] <= {bus_io.alu_rob_idx, res, br};
   end

   assign head_ent             = mem_q[head_q];
   assign bus_io.cdb_alu_valid = cnt_q != '0;
   assign bus_io.cdb_alu_src   = bus_io.cdb_alu_valid ? head_ent[EntW-1 -: 4] : '0;
   assign bus_io.cdb_alu_val   = bus_io.cdb_alu_valid ? head_ent[32:1] : '0;
   assign bus_io.cdb_alu_br    = bus_io.cdb_alu_valid & head_ent[0];
   // Two slots of headroom: one issue may already sit in the RS output register.
   assign bus_io.ex_full       = cnt_q >= cnt_t'(Depth - 2);
endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus pushes hand-computed results, a negedge monitor
// compares the CDB head and the near-full flag against the queued expectation.
module tb_alu_exec;
   localparam logic [4:0] OPT_NONE  = 5'd0;
   localparam logic [4:0] OPT_SUB   = 5'd2;
   localparam logic [4:0] OPT_SRL   = 5'd7;
   localparam logic [4:0] OPT_SRA   = 5'd8;
   localparam logic [4:0] OPT_SLT   = 5'd9;
   localparam logic [4:0] OPT_SLTU  = 5'd10;
   localparam logic [4:0] OPT_ADDI  = 5'd11;
   localparam logic [4:0] OPT_XORI  = 5'd14;
   localparam logic [4:0] OPT_SLLI  = 5'd15;
   localparam logic [4:0] OPT_SRAI  = 5'd17;
   localparam logic [4:0] OPT_SLTIU = 5'd19;
   localparam logic [4:0] OPT_LUI   = 5'd20;
   localparam logic [4:0] OPT_AUIPC = 5'd21;
   localparam logic [4:0] OPT_JAL   = 5'd22;
   localparam logic [4:0] OPT_JALR  = 5'd23;
   localparam logic [4:0] OPT_BEQ   = 5'd24;
   localparam logic [4:0] OPT_BNE   = 5'd25;
   localparam logic [4:0] OPT_BLT   = 5'd26;
   localparam logic [4:0] OPT_BGE   = 5'd27;
   localparam logic [4:0] OPT_BLTU  = 5'd28;
   localparam logic [4:0] OPT_BGEU  = 5'd29;
   localparam int         Depth     = 4;

   typedef struct {
      logic [3:0]  tag;
      logic [31:0] val;
      logic        br;
   } exp_t;

   typedef struct {
      logic [4:0]  opt;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] imm;
      logic [31:0] ev;
      logic        eb;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   exp_t sb[$];
   vec_t vecs[$];
   int   n_chk = 0;
   int   n_fail = 0;
   logic [3:0] next_tag = 4'd1;

   always #5 clk = ~clk;

   alu_exec_if bus ();

   alu_exec #(.FIFO_BIT(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      chk("valid", 32'(bus.cdb_alu_valid), 32'(sb.size() != 0));
      chk("ex_full", 32'(bus.ex_full), 32'(sb.size() >= Depth - 2));
      if (sb.size() == 0) begin
         chk("idle_src", 32'(bus.cdb_alu_src), 32'd0);
         chk("idle_val", bus.cdb_alu_val, 32'd0);
         chk("idle_br", 32'(bus.cdb_alu_br), 32'd0);
      end else begin
         chk("src", 32'(bus.cdb_alu_src), 32'(sb[0].tag));
         chk("val", bus.cdb_alu_val, sb[0].val);
         chk("br", 32'(bus.cdb_alu_br), 32'(sb[0].br));
         if (rst && bus.rdy && !bus.ex_rb && bus.cdb_alu_gnt) void'(sb.pop_front());
      end
   end

   task automatic step(input logic ena, input logic [4:0] opt, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] imm, input logic [31:0] ev,
                       input logic eb, input logic gnt);
      logic [3:0] tag;
      tag             = next_tag;
      bus.alu_ena     = ena;
      bus.alu_opt     = opt;
      bus.alu_val1    = v1;
      bus.alu_val2    = v2;
      bus.alu_imm     = imm;
      bus.alu_rob_idx = tag;
      bus.cdb_alu_gnt = gnt;
      @(posedge clk);
      if (ena && rst && bus.rdy && !bus.ex_rb) begin
         n_chk++;
         if (sb.size() >= Depth) begin
            n_fail++;
            $display("FAIL overflow: issue while %0d entries queued", sb.size());
         end else begin
            sb.push_back('{tag: tag, val: ev, br: eb});
         end
         next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
      end
      if (bus.ex_rb && rst) sb.delete();
      #1;
   endtask

   task automatic idle(input logic gnt);
      step(1'b0, OPT_NONE, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, gnt);
   endtask

   task automatic addi(input logic [31:0] v1, input logic [31:0] imm, input logic gnt);
      step(1'b1, OPT_ADDI, v1, 32'd0, imm, v1 + imm, 1'b0, gnt);
   endtask

   initial begin
      bus.rdy = 1'b1;
      bus.ex_rb = 1'b0;
      bus.alu_ena = 1'b0;
      bus.alu_opt = OPT_NONE;
      bus.alu_val1 = '0;
      bus.alu_val2 = '0;
      bus.alu_imm = '0;
      bus.alu_rob_idx = '0;
      bus.cdb_alu_gnt = 1'b0;
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.cdb_alu_valid), 32'd0);
      chk("rst_full", 32'(bus.ex_full), 32'd0);
      chk("rst_val", bus.cdb_alu_val, 32'd0);
      rst = 1'b1;
      idle(1'b1);

      next_tag = 4'd5;
      addi(32'hFFFF_FFFF, 32'd1, 1'b1);
      idle(1'b1);
      idle(1'b1);

      vecs.push_back('{OPT_SRA,   32'h8000_0000, 32'h21,        32'd0,         32'hC000_0000, 1'b0});
      vecs.push_back('{OPT_SLTU,  32'h8000_0000, 32'd1,         32'd0,         32'd0,         1'b0});
      vecs.push_back('{OPT_SLT,   32'h8000_0000, 32'd1,         32'd0,         32'd1,         1'b0});
      vecs.push_back('{OPT_BLT,   32'hFFFF_FFFF, 32'd0,         32'd0,         32'd0,         1'b1});
      vecs.push_back('{OPT_JAL,   32'h0000_1000, 32'd0,         32'd0,         32'h0000_1004, 1'b1});
      vecs.push_back('{OPT_SUB,   32'd5,         32'd7,         32'd0,         32'hFFFF_FFFE, 1'b0});
      vecs.push_back('{OPT_XORI,  32'hF0F0_F0F0, 32'd0,         32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0});
      vecs.push_back('{OPT_SLLI,  32'd1,         32'd0,         32'h3F,        32'h8000_0000, 1'b0});
      vecs.push_back('{OPT_SRL,   32'h8000_0000, 32'd4,         32'd0,         32'h0800_0000, 1'b0});
      vecs.push_back('{OPT_LUI,   32'h1111_1111, 32'd0,         32'h1234_5000, 32'h1234_5000, 1'b0});
      vecs.push_back('{OPT_AUIPC, 32'h0000_1000, 32'd0,         32'h0000_2000, 32'h0000_3000, 1'b0});
      vecs.push_back('{OPT_BGEU,  32'd1,         32'hFFFF_FFFF, 32'd0,         32'd0,         1'b0});
      vecs.push_back('{OPT_BEQ,   32'd7,         32'd7,         32'd0,         32'd0,         1'b1});
      vecs.push_back('{OPT_BNE,   32'd1,         32'd2,         32'd0,         32'd0,         1'b1});
      vecs.push_back('{OPT_BGE,   32'hFFFF_FFFF, 32'd0,         32'd0,         32'd0,         1'b0});
      vecs.push_back('{OPT_BLTU,  32'd0,         32'd1,         32'd0,         32'd0,         1'b1});
      vecs.push_back('{OPT_JALR,  32'hFFFF_FFFC, 32'd0,         32'd0,         32'd0,         1'b1});
      vecs.push_back('{OPT_SLTIU, 32'd0,         32'd0,         32'hFFFF_FFFF, 32'd1,         1'b0});
      vecs.push_back('{OPT_SRAI,  32'h8000_0000, 32'd0,         32'd31,        32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{OPT_NONE,  32'd9,         32'd9,         32'd9,         32'd0,         1'b0});
      vecs.push_back('{5'd31,     32'd9,         32'd9,         32'd9,         32'd0,         1'b0});
      foreach (vecs[i]) begin
         step(1'b1, vecs[i].opt, vecs[i].v1, vecs[i].v2, vecs[i].imm, vecs[i].ev, vecs[i].eb,
              1'b1);
      end
      idle(1'b1);
      idle(1'b1);

      // Fill with grant held off, then drain in order.
      next_tag = 4'd1;
      for (int i = 1; i <= 4; i++) addi(32'h100, 32'(i), 1'b0);
      idle(1'b0);
      repeat (5) idle(1'b1);

      // Full FIFO with simultaneous issue and grant: pointers wrap several times.
      for (int i = 0; i < 4; i++) addi(32'h2000, 32'(i), 1'b0);
      for (int i = 0; i < 10; i++) addi(32'h3000, 32'(i), 1'b1);
      repeat (6) idle(1'b1);

      // rdy low freezes everything, grant and issue included.
      addi(32'h40, 32'd1, 1'b0);
      addi(32'h40, 32'd2, 1'b0);
      bus.rdy = 1'b0;
      repeat (3) addi(32'h50, 32'd0, 1'b1);
      bus.rdy = 1'b1;
      repeat (4) idle(1'b1);

      // Rollback together with an issue and a grant.
      for (int i = 0; i < 3; i++) addi(32'h600, 32'(i), 1'b0);
      bus.ex_rb = 1'b1;
      addi(32'h700, 32'd0, 1'b1);
      bus.ex_rb = 1'b0;
      repeat (3) idle(1'b1);

      // Asynchronous reset while draining.
      for (int i = 0; i < 3; i++) addi(32'h800, 32'(i), 1'b0);
      idle(1'b1);
      #2 rst = 1'b0;
      sb.delete();
      #1;
      chk("arst_valid", 32'(bus.cdb_alu_valid), 32'd0);
      chk("arst_full", 32'(bus.ex_full), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      addi(32'h900, 32'd1, 1'b1);

      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
      chk("drain", 32'(sb.size()), 32'd0);
      idle(1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
